// File: rtl/dec_pkg.sv
// dec_pkg: opcode constants, control encodings and decoded bundle types for the decode stage
package dec_pkg;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_ZIMM} imm_op_t;
   typedef enum logic [1:0] {SEL_A_RS1, SEL_A_PC, SEL_A_ZERO} sel_a_t;
   typedef enum logic [1:0] {SEL_B_RS2, SEL_B_IMM, SEL_B_FOUR} sel_b_t;
   typedef struct packed {
      logic [2:0]  funct3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [11:0] csr_addr;
      imm_op_t     imm_op;
      sel_a_t      sel_a;
      sel_b_t      sel_b;
      logic [3:0]  alu_op;
      logic        is_op;
      logic        is_lui;
      logic        is_auipc;
      logic        is_jal;
      logic        is_jalr;
      logic        is_branch;
      logic        is_ld;
      logic        is_st;
      logic        is_misc_mem;
      logic        is_system;
      logic        is_muldiv;
      logic        illegal;
   } dec_ctrl_t;
   typedef struct packed {
      dec_ctrl_t   ctrl;
      logic [31:0] imm;
      logic [31:0] pc;
   } bundle_t;
   function automatic logic [31:0] gen_imm(input imm_op_t op, input logic [31:0] i);
      case (op)
         IMM_I:     return {{20{i[31]}}, i[31:20]};
         IMM_S:     return {{20{i[31]}}, i[31:25], i[11:7]};
         IMM_B:     return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         IMM_U:     return {i[31:12], 12'b0};
         IMM_J:     return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         IMM_SHAMT: return {27'b0, i[24:20]};
         IMM_ZIMM:  return {27'b0, i[19:15]};
         default:   return '0;
      endcase
   endfunction
endpackage

// File: rtl/dec_comb.sv
// dec_comb: combinational RV32I(+M) instruction word to control bundle and immediate decoder
module dec_comb
   import dec_pkg::*;
#(
   parameter bit ENABLE_M      = 1'b0,
   parameter bit ENABLE_FENCEI = 1'b0
) (
   input  logic [31:0] instr,
   output dec_ctrl_t   ctrl,
   output logic [31:0] imm
);
   logic [6:0] opc, f7;
   logic [2:0] f3;
   logic       sh, mul, bad;
   dec_ctrl_t  d;
   assign opc = instr[6:0];
   assign f3  = instr[14:12];
   assign f7  = instr[31:25];
   assign sh  = f3[1:0] == 2'b01;
   assign mul = ENABLE_M && f7 == 7'b0000001;
   always_comb begin
      d = '0;
      d.funct3 = f3;
      d.rs1 = instr[19:15];
      d.rs2 = instr[24:20];
      d.rd = instr[11:7];
      d.imm_op = IMM_NONE;
      d.sel_a = SEL_A_RS1;
      d.sel_b = SEL_B_RS2;
      d.alu_op = ALU_ADD;
      bad = 1'b0;
      case (opc)
         OPC_LOAD: begin
            d.is_ld = 1'b1;
            d.imm_op = IMM_I;
            d.sel_b = SEL_B_IMM;
         end
         OPC_STORE: begin
            d.is_st = 1'b1;
            d.imm_op = IMM_S;
            d.sel_b = SEL_B_IMM;
         end
         OPC_BRANCH: begin
            d.is_branch = 1'b1;
            d.imm_op = IMM_B;
         end
         OPC_JAL: begin
            d.is_jal = 1'b1;
            d.imm_op = IMM_J;
            d.sel_a = SEL_A_PC;
            d.sel_b = SEL_B_FOUR;
         end
         OPC_JALR: begin
            d.is_jalr = 1'b1;
            d.imm_op = IMM_I;
            d.sel_a = SEL_A_PC;
            d.sel_b = SEL_B_FOUR;
         end
         OPC_LUI: begin
            d.is_lui = 1'b1;
            d.imm_op = IMM_U;
            d.sel_a = SEL_A_ZERO;
            d.sel_b = SEL_B_IMM;
         end
         OPC_AUIPC: begin
            d.is_auipc = 1'b1;
            d.imm_op = IMM_U;
            d.sel_a = SEL_A_PC;
            d.sel_b = SEL_B_IMM;
         end
         OPC_OP_IMM: begin
            d.is_op = 1'b1;
            d.imm_op = sh ? IMM_SHAMT : IMM_I;
            d.sel_b = SEL_B_IMM;
            d.alu_op = {sh & instr[30], f3};
            bad = sh && !(f7 == 7'b0000000 || (f7 == 7'b0100000 && f3 == 3'b101));
         end
         OPC_OP: begin
            d.is_op = 1'b1;
            d.is_muldiv = mul;
            d.alu_op = {instr[30] & !mul, f3};
            bad = !(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) || mul);
         end
         OPC_MISC_MEM: begin
            d.is_misc_mem = 1'b1;
            bad = !(f3 == 3'b000 || (ENABLE_FENCEI && f3 == 3'b001));
         end
         OPC_SYSTEM: begin
            d.is_system = 1'b1;
            d.csr_addr = instr[31:20];
            d.imm_op = f3[2] ? IMM_ZIMM : IMM_NONE;
            bad = f3 == 3'b100;
         end
         default: bad = 1'b1;
      endcase
      if (!(opc == OPC_OP || opc == OPC_BRANCH || opc == OPC_STORE)) d.rs2 = '0;
      if (opc == OPC_BRANCH || opc == OPC_STORE) d.rd = '0;
      // Illegal words travel as an empty bundle so nothing downstream acts on them
      if (bad) begin
         d = '0;
         d.illegal = 1'b1;
      end
   end
   assign ctrl = d;
   assign imm = gen_imm(d.imm_op, instr);
endmodule

// File: rtl/decode_stage.sv
// decode_stage: decode pipeline stage with main+skid buffering and registered ready
module decode_stage
   import dec_pkg::*;
#(
   parameter bit ENABLE_M      = 1'b0,
   parameter bit ENABLE_FENCEI = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  logic        if_valid_i,
   output logic        if_ready_o,
   input  logic [31:0] if_instr_i,
   input  logic [31:0] if_pc_i,
   output logic        id_valid_o,
   input  logic        id_ready_i,
   output dec_ctrl_t   id_ctrl_o,
   output logic [31:0] id_imm_o,
   output logic [31:0] id_pc_o,
   output logic [31:0] dec_count_o
);
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
   state_t      state, nxt;
   dec_ctrl_t   dctrl;
   logic [31:0] dimm, count;
   bundle_t     word, main, skid;
   logic        rdy, acc, dlv, load_main, load_skid, pop_skid;
   dec_comb #(.ENABLE_M(ENABLE_M), .ENABLE_FENCEI(ENABLE_FENCEI)) u_dec (
      .instr(if_instr_i),
      .ctrl (dctrl),
      .imm  (dimm)
   );
   assign word = '{ctrl: dctrl, imm: dimm, pc: if_pc_i};
   assign acc = if_valid_i & rdy;
   assign dlv = id_valid_o & id_ready_i;
   assign id_valid_o = state != EMPTY;
   assign if_ready_o = rdy;
   assign id_ctrl_o = main.ctrl;
   assign id_imm_o = main.imm;
   assign id_pc_o = main.pc;
   assign dec_count_o = count;
   always_comb begin
      load_main = acc && (state == EMPTY || dlv);
      load_skid = acc && state == ONE && !dlv;
      pop_skid = dlv && state == TWO;
      nxt = flush_i ? EMPTY : load_skid ? TWO : (pop_skid || load_main) ? ONE : dlv ? EMPTY : state;
   end
   // Ready is a flop computed from the next state, so id_ready_i never reaches if_ready_o
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= EMPTY;
         rdy <= 1'b1;
      end else begin
         state <= nxt;
         rdy <= nxt != TWO;
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         main <= '0;
         skid <= '0;
         count <= '0;
      end else begin
         if (pop_skid) main <= skid;
         else if (load_main) main <= word;
         if (load_skid) skid <= word;
         if (dlv && !flush_i) count <= count + 32'd1;
      end
   end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage (base and M/FENCE.I builds)
module tb_decode_stage;
   import dec_pkg::*;
   logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, if_valid = 1'b0, id_ready = 1'b0;
   logic [31:0] if_instr = '0, if_pc = '0;
   logic        if_ready, id_valid, if_ready_m, id_valid_m;
   dec_ctrl_t   ctrl, ctrl_m;
   logic [31:0] imm, pc, cnt, imm_m, pc_m, cnt_m;
   int          checks = 0, failures = 0;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .if_valid_i(if_valid), .if_ready_o(if_ready),
      .if_instr_i(if_instr), .if_pc_i(if_pc), .id_valid_o(id_valid), .id_ready_i(id_ready),
      .id_ctrl_o(ctrl), .id_imm_o(imm), .id_pc_o(pc), .dec_count_o(cnt)
   );

   decode_stage #(.ENABLE_M(1'b1), .ENABLE_FENCEI(1'b1)) dut_m (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .if_valid_i(if_valid), .if_ready_o(if_ready_m),
      .if_instr_i(if_instr), .if_pc_i(if_pc), .id_valid_o(id_valid_m), .id_ready_i(id_ready),
      .id_ctrl_o(ctrl_m), .id_imm_o(imm_m), .id_pc_o(pc_m), .dec_count_o(cnt_m)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p);
      if_valid = v;
      if_instr = i;
      if_pc = p;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_valid", 64'(id_valid), 64'h0);
      check("rst_ready", 64'(if_ready), 64'h1);
      check("rst_ctrl", 64'(ctrl), 64'h0);
      check("rst_pc", 64'(pc), 64'h0);
      check("rst_count", 64'(cnt), 64'h0);
      rst_n = 1'b1;
      id_ready = 1'b1;
      drive(1'b1, 32'h00500093, 32'h100);
      @(negedge clk);
      check("addi_valid", 64'(id_valid), 64'h1);
      check("addi_rd", 64'(ctrl.rd), 64'h1);
      check("addi_rs1", 64'(ctrl.rs1), 64'h0);
      check("addi_rs2", 64'(ctrl.rs2), 64'h0);
      check("addi_imm", 64'(imm), 64'h5);
      check("addi_alu", 64'(ctrl.alu_op), 64'(ALU_ADD));
      check("addi_is_op", 64'(ctrl.is_op), 64'h1);
      check("addi_pc", 64'(pc), 64'h100);
      check("addi_cnt0", 64'(cnt), 64'h0);
      drive(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("addi_cnt1", 64'(cnt), 64'h1);
      check("addi_drained", 64'(id_valid), 64'h0);
      // back-to-back with downstream stalled
      id_ready = 1'b0;
      drive(1'b1, 32'h002081B3, 32'h200);
      @(negedge clk);
      check("b2b_valid", 64'(id_valid), 64'h1);
      check("b2b_ready1", 64'(if_ready), 64'h1);
      drive(1'b1, 32'h40208233, 32'h204);
      @(negedge clk);
      check("b2b_ready2", 64'(if_ready), 64'h0);
      check("b2b_hold_pc", 64'(pc), 64'h200);
      drive(1'b1, 32'h123452B7, 32'h208);
      @(negedge clk);
      check("b2b_stall_pc", 64'(pc), 64'h200);
      check("b2b_stall_alu", 64'(ctrl.alu_op), 64'(ALU_ADD));
      check("b2b_stall_ready", 64'(if_ready), 64'h0);
      id_ready = 1'b1;
      @(negedge clk);
      check("b2b_d1_pc", 64'(pc), 64'h204);
      check("b2b_d1_alu", 64'(ctrl.alu_op), 64'(ALU_SUB));
      check("b2b_d1_ready", 64'(if_ready), 64'h1);
      check("b2b_d1_cnt", 64'(cnt), 64'h2);
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0);
      check("b2b_d2_pc", 64'(pc), 64'h208);
      check("b2b_d2_imm", 64'(imm), 64'h12345000);
      check("b2b_d2_lui", 64'(ctrl.is_lui), 64'h1);
      check("b2b_d2_sela", 64'(ctrl.sel_a), 64'(SEL_A_ZERO));
      check("b2b_d2_cnt", 64'(cnt), 64'h3);
      @(negedge clk);
      check("b2b_empty", 64'(id_valid), 64'h0);
      check("b2b_cnt", 64'(cnt), 64'h4);
      // decode patterns, one per cycle
      drive(1'b1, 32'h02208033, 32'h300);
      @(negedge clk);
      check("mul_illegal", 64'(ctrl.illegal), 64'h1);
      check("mul_is_op", 64'(ctrl.is_op), 64'h0);
      check("mul_imm", 64'(imm), 64'h0);
      check("mul_pc", 64'(pc), 64'h300);
      check("mul_m_muldiv", 64'(ctrl_m.is_muldiv), 64'h1);
      check("mul_m_is_op", 64'(ctrl_m.is_op), 64'h1);
      check("mul_m_illegal", 64'(ctrl_m.illegal), 64'h0);
      check("mul_m_rd", 64'(ctrl_m.rd), 64'h0);
      check("mul_m_rs1", 64'(ctrl_m.rs1), 64'h1);
      check("mul_m_rs2", 64'(ctrl_m.rs2), 64'h2);
      check("mul_m_alu", 64'(ctrl_m.alu_op), 64'h0);
      check("mul_m_pc", 64'(pc_m), 64'h300);
      drive(1'b1, 32'h0020A423, 32'h304);
      @(negedge clk);
      check("sw_imm", 64'(imm), 64'h8);
      check("sw_rd", 64'(ctrl.rd), 64'h0);
      check("sw_rs2", 64'(ctrl.rs2), 64'h2);
      check("sw_is_st", 64'(ctrl.is_st), 64'h1);
      drive(1'b1, 32'hFE208EE3, 32'h308);
      @(negedge clk);
      check("beq_imm", 64'(imm), 64'hFFFFFFFC);
      check("beq_rd", 64'(ctrl.rd), 64'h0);
      check("beq_rs2", 64'(ctrl.rs2), 64'h2);
      check("beq_branch", 64'(ctrl.is_branch), 64'h1);
      drive(1'b1, 32'h001000EF, 32'h30C);
      @(negedge clk);
      check("jal_imm", 64'(imm), 64'h800);
      check("jal_rd", 64'(ctrl.rd), 64'h1);
      check("jal_rs2", 64'(ctrl.rs2), 64'h0);
      check("jal_selb", 64'(ctrl.sel_b), 64'(SEL_B_FOUR));
      check("jal_is_jal", 64'(ctrl.is_jal), 64'h1);
      drive(1'b1, 32'h305FD0F3, 32'h310);
      @(negedge clk);
      check("csri_imm", 64'(imm), 64'h1F);
      check("csri_addr", 64'(ctrl.csr_addr), 64'h305);
      check("csri_system", 64'(ctrl.is_system), 64'h1);
      check("csri_m_imm", 64'(imm_m), 64'h1F);
      drive(1'b1, 32'h41F0D093, 32'h314);
      @(negedge clk);
      check("srai_imm", 64'(imm), 64'h1F);
      check("srai_alu", 64'(ctrl.alu_op), 64'(ALU_SRA));
      check("srai_illegal", 64'(ctrl.illegal), 64'h0);
      drive(1'b1, 32'h40109093, 32'h318);
      @(negedge clk);
      check("slli_bad_illegal", 64'(ctrl.illegal), 64'h1);
      check("slli_bad_is_op", 64'(ctrl.is_op), 64'h0);
      drive(1'b1, 32'h0000100F, 32'h31C);
      @(negedge clk);
      check("fencei_illegal", 64'(ctrl.illegal), 64'h1);
      check("fencei_m_illegal", 64'(ctrl_m.illegal), 64'h0);
      check("fencei_m_misc", 64'(ctrl_m.is_misc_mem), 64'h1);
      drive(1'b1, 32'h00000000, 32'h320);
      @(negedge clk);
      check("zero_illegal", 64'(ctrl.illegal), 64'h1);
      check("zero_pc", 64'(pc), 64'h320);
      drive(1'b1, 32'h00004073, 32'h324);
      @(negedge clk);
      check("sys100_illegal", 64'(ctrl.illegal), 64'h1);
      check("sys100_system", 64'(ctrl.is_system), 64'h0);
      drive(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("seq_cnt", 64'(cnt), 64'd14);
      check("seq_m_cnt", 64'(cnt_m), 64'd14);
      // flush from TWO with a word offered
      id_ready = 1'b0;
      drive(1'b1, 32'h002081B3, 32'h400);
      @(negedge clk);
      drive(1'b1, 32'h40208233, 32'h404);
      @(negedge clk);
      check("fl_two", 64'(if_ready), 64'h0);
      flush = 1'b1;
      drive(1'b1, 32'h123452B7, 32'h408);
      @(negedge clk);
      check("fl_valid", 64'(id_valid), 64'h0);
      check("fl_ready", 64'(if_ready), 64'h1);
      check("fl_m_valid", 64'(id_valid_m), 64'h0);
      check("fl_m_ready", 64'(if_ready_m), 64'h1);
      check("fl_cnt", 64'(cnt), 64'd14);
      flush = 1'b0;
      id_ready = 1'b1;
      drive(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("fl_nothing_kept", 64'(id_valid), 64'h0);
      check("fl_cnt_after", 64'(cnt), 64'd14);
      // asynchronous reset mid-cycle in TWO
      id_ready = 1'b0;
      drive(1'b1, 32'h002081B3, 32'h500);
      @(negedge clk);
      drive(1'b1, 32'h40208233, 32'h504);
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0);
      check("ar_two", 64'(if_ready), 64'h0);
      #2 rst_n = 1'b0;
      #1;
      check("ar_valid", 64'(id_valid), 64'h0);
      check("ar_ready", 64'(if_ready), 64'h1);
      check("ar_ctrl", 64'(ctrl), 64'h0);
      check("ar_imm", 64'(imm), 64'h0);
      check("ar_pc", 64'(pc), 64'h0);
      check("ar_cnt", 64'(cnt), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      // counter wrap
      force dut.count = 32'hFFFFFFFF;
      #1 release dut.count;
      check("wrap_preload", 64'(cnt), 64'hFFFFFFFF);
      id_ready = 1'b1;
      drive(1'b1, 32'h00500093, 32'h600);
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0);
      check("wrap_accept", 64'(id_valid), 64'h1);
      check("wrap_before", 64'(cnt), 64'hFFFFFFFF);
      @(negedge clk);
      check("wrap_zero", 64'(cnt), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter ENABLE_M, default 0, 1 = decode RV32M (funct7 0000001 under OP).
REQ-002 Parameter ENABLE_FENCEI, default 0, 1 = MISC_MEM funct3 001 is legal.
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 flush_i  in  1  synchronous pipeline flush.
REQ-006 if_valid_i  in  1  fetch word valid.
REQ-007 if_ready_o  out  1  stage can accept.
REQ-008 if_instr_i  in  32  instruction word.
REQ-009 if_pc_i  in  32  instruction PC.
REQ-010 id_valid_o  out  1  decoded bundle valid.
REQ-011 id_ready_i  in  1  downstream accepts.
REQ-012 id_ctrl_o  out  dec_ctrl_t  decoded control bundle.
REQ-013 id_imm_o  out  32  sign/zero-extended immediate, fully generated.
REQ-014 id_pc_o  out  32  PC of bundle.
REQ-015 dec_count_o  out  32  count of bundles delivered downstream.

Function
REQ-016 Accept = if_valid_i & if_ready_o; deliver = id_valid_o & id_ready_i.
REQ-017 Storage: main register plus one skid register; states EMPTY, ONE (main), TWO (main+skid).
REQ-018 if_ready_o is registered; 1 in EMPTY/ONE, 0 in TWO; no combinational path from id_ready_i.
REQ-019 Latency: accepted word appears on id_valid_o the next cycle; throughput one per cycle while id_ready_i=1.
REQ-020 EMPTY+accept -> ONE; ONE+accept+deliver -> ONE (main reloaded); ONE+accept+!deliver -> TWO (word to skid); ONE+deliver+!accept -> EMPTY; TWO+deliver -> ONE (skid moves to main).
REQ-021 Bundle on id_* holds stable while id_valid_o=1 and id_ready_i=0; program order preserved.
REQ-022 Decoding is combinational on the incoming word and registered at accept; decoded fields stored, not the raw word.
REQ-023 Ctrl fields: funct3, rs1, rs2, rd, csr_addr, imm_op, sel_a, sel_b, alu_op, is_op, is_lui, is_auipc, is_jal, is_jalr, is_branch, is_ld, is_st, is_misc_mem, is_system, is_muldiv, illegal.
REQ-024 rs2 forced 0 unless OP, BRANCH or STORE; rd forced 0 for BRANCH and STORE.
REQ-025 OP alu_op = {instr[30], funct3}; OP_IMM alu_op = {instr[30], funct3} for funct3 001/101, else {0, funct3}.
REQ-026 illegal=1 when: instr[1:0]!=11; unknown opcode; OP funct7 not 0000000, nor 0100000 with funct3 000/101, nor (ENABLE_M & 0000001); OP_IMM shift with instr[31:25] not 0000000/0100000 or 0100000 on SLLI; SYSTEM funct3 100; MISC_MEM funct3 not 000 (or 001 with ENABLE_FENCEI).
REQ-027 Illegal words still flow with illegal=1, all is_* 0, id_pc_o valid, id_imm_o 0.
REQ-028 is_muldiv=1 only when ENABLE_M and OP funct7 0000001; alu_op then {0, funct3}.
REQ-029 id_imm_o per imm_op: I, S, B, U, J sign-extended RV32 forms; shamt zero-extended instr[24:20]; CSR zimm zero-extended instr[19:15].
REQ-030 flush_i: both registers invalidated next edge; overrides same-cycle accept and deliver; if_ready_o=1 the cycle after.
REQ-031 dec_count_o increments by 1 per deliver, wraps 0xFFFFFFFF -> 0, not cleared by flush.

Reset
REQ-032 On rst_ni low: state EMPTY, id_valid_o=0, if_ready_o=1, id_ctrl_o/id_imm_o/id_pc_o=0, dec_count_o=0, regardless of in-flight words.
REQ-033 First accept possible on the first rising edge after rst_ni deasserts.

Structure
REQ-034 Package dec_pkg holds opcode constants, IMM_*, SEL_*, ALU_* codes and dec_ctrl_t.
REQ-035 Sub-module dec_comb: pure combinational word -> (dec_ctrl_t, imm) decoder, instantiated once on the input side.

Verification
REQ-036 ADDI 0x00500093, id_ready_i=1 -> next cycle id_valid_o=1, rd=1, rs1=0, rs2=0, imm=5, alu_op=ADD, is_op=1, dec_count_o 0->1.
REQ-037 Three back-to-back words, id_ready_i=0 -> first two accepted, if_ready_o=0 after second; release ready -> delivered in order on consecutive cycles.
REQ-038 MUL 0x02208033: ENABLE_M=0 -> illegal=1, is_op=0; ENABLE_M=1 -> is_muldiv=1, is_op=1, rd=0, rs1=1, rs2=2.
REQ-039 State TWO, flush_i=1 with if_valid_i=1 -> next cycle id_valid_o=0, if_ready_o=1, no word retained, dec_count_o unchanged.
REQ-040 rst_ni pulsed low in TWO mid-cycle -> outputs zero immediately, asynchronously; dec_count_o preloaded 0xFFFFFFFF plus one deliver -> 0.
